// File: rtl/uart_tx_drain.sv
// UART transmitter that drains an upstream show-ahead FIFO, one frame per popped word.
// Optional even-parity bit is compiled in when UART_TX_DRAIN_PARITY_EN is defined.
module uart_tx_drain #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_pop,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [TW-1:0] T_LOAD   = TW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_DRAIN_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [TW-1:0]    timer_reg, timer_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             tx_reg, tx_next;
`ifdef UART_TX_DRAIN_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  logic bit_end;
  logic start_ok;

  assign bit_end  = (timer_reg == '0);
  // A new frame may begin from idle or in the final stop cycle, giving gapless back-to-back frames.
  assign start_ok = en && !fifo_empty &&
                    ((state_reg == S_IDLE) || ((state_reg == S_STOP) && bit_end));

  assign fifo_pop   = start_ok && !rst;
  assign frame_done = (state_reg == S_STOP) && bit_end && !rst;
  assign busy       = (state_reg != S_IDLE);
  assign tx         = tx_reg;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
`ifdef UART_TX_DRAIN_PARITY_EN
    parity_next = parity_reg;
`endif

    if ((state_reg != S_IDLE) && !bit_end) begin
      timer_next = timer_reg - 1'b1;
    end

    if (start_ok) begin
      state_next = S_START;
      timer_next = T_LOAD;
      idx_next   = '0;
      shift_next = fifo_rdata;
      tx_next    = 1'b0;
`ifdef UART_TX_DRAIN_PARITY_EN
      parity_next = ^fifo_rdata;
`endif
    end else if (bit_end) begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_IDLE;
        end
        S_START: begin
          state_next = S_DATA;
          timer_next = T_LOAD;
          tx_next    = shift_reg[0];
        end
        S_DATA: begin
          timer_next = T_LOAD;
          if (idx_reg == LAST_IDX) begin
`ifdef UART_TX_DRAIN_PARITY_EN
            state_next = S_PARITY;
            tx_next    = parity_reg;
`else
            state_next = S_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            idx_next   = idx_reg + 1'b1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end
`ifdef UART_TX_DRAIN_PARITY_EN
        S_PARITY: begin
          state_next = S_STOP;
          timer_next = T_LOAD;
          tx_next    = 1'b1;
        end
`endif
        S_STOP: begin
          state_next = S_IDLE;
          tx_next    = 1'b1;
        end
        default: begin
          state_next = S_IDLE;
          tx_next    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      timer_reg <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
`ifdef UART_TX_DRAIN_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
`ifdef UART_TX_DRAIN_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain (WIDTH=8, CLK_DIV=4): fixed vector table, directed frame sequences,
// and random traffic checked cycle by cycle against a frame-level waveform model.
module tb_uart_tx_drain;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_rdata = '0;
  logic         fifo_pop, tx, busy, frame_done;

  uart_tx_drain #(.WIDTH(W), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_pop(fifo_pop), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: expected tx level for the current and all remaining cycles of the frame in flight.
  bit           frame_q[$];
  logic [W-1:0] fifo_q[$];
  int cyc, pop_cnt, busy_cnt, busy_run, busy_run_max, last_done;
  int pop_cyc[$];

  function automatic void push_frame(input logic [W-1:0] w);
    bit par = 1'b0;
    for (int k = 0; k < D; k++) frame_q.push_back(1'b0);
    for (int b = 0; b < W; b++) begin
      par ^= w[b];
      for (int k = 0; k < D; k++) frame_q.push_back(w[b]);
    end
`ifdef UART_TX_DRAIN_PARITY_EN
    for (int k = 0; k < D; k++) frame_q.push_back(par);
`endif
    for (int k = 0; k < D; k++) frame_q.push_back(1'b1);
  endfunction

  task automatic clear_stats();
    cyc = 0; pop_cnt = 0; busy_cnt = 0; busy_run = 0; busy_run_max = 0; last_done = -1;
    pop_cyc.delete();
  endtask

  task automatic run_cycle(input bit r, input bit e, input bit hold_empty);
    bit x_tx, x_busy, x_pop, x_done;
    rst = r;
    en = e;
    fifo_empty = hold_empty || (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? W'($urandom) : fifo_q[0];
    x_busy = (frame_q.size() > 0);
    x_tx   = x_busy ? frame_q[0] : 1'b1;
    x_done = !r && (frame_q.size() == 1);
    x_pop  = !r && e && !fifo_empty && (frame_q.size() <= 1);
    #2;
    chk("tx", int'(tx), int'(x_tx));
    chk("busy", int'(busy), int'(x_busy));
    chk("fifo_pop", int'(fifo_pop), int'(x_pop));
    chk("frame_done", int'(frame_done), int'(x_done));
    if (fifo_pop) begin pop_cnt++; pop_cyc.push_back(cyc); end
    if (busy) begin
      busy_cnt++; busy_run++;
      if (busy_run > busy_run_max) busy_run_max = busy_run;
    end else busy_run = 0;
    if (frame_done) last_done = cyc;
    @(posedge clk);
    if (r) frame_q.delete();
    else begin
      if (frame_q.size() > 0) void'(frame_q.pop_front());
      if (x_pop) begin
        push_frame(fifo_rdata);
        void'(fifo_q.pop_front());
      end
    end
    cyc++;
    #1;
  endtask

  task automatic raw_reset();
    rst = 1'b1; en = 1'b0; fifo_empty = 1'b1;
    @(posedge clk); #1;
    frame_q.delete();
    fifo_q.delete();
  endtask

  function automatic int pop_at(input int i);
    return (pop_cyc.size() > i) ? pop_cyc[i] : -1000;
  endfunction

  typedef struct {
    bit r, e, empty;
    logic [W-1:0] data;
    bit x_tx, x_busy, x_pop, x_done;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input bit r, e, empty, input logic [W-1:0] d,
                              input bit t, b, p, dn, input int reps);
    vec_t v;
    v.r = r; v.e = e; v.empty = empty; v.data = d;
    v.x_tx = t; v.x_busy = b; v.x_pop = p; v.x_done = dn;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endfunction

  initial begin
    // Reset hold, single pop of 0xA5, start bit, then data bits 1,0,1 (en low later has no effect).
    add(1, 1, 0, 8'hA5, 1, 0, 0, 0, 3);
    add(0, 1, 0, 8'hA5, 1, 0, 1, 0, 1);
    add(0, 1, 1, 8'h00, 0, 1, 0, 0, 4);
    add(0, 1, 1, 8'h00, 1, 1, 0, 0, 4);
    add(0, 1, 0, 8'hFF, 0, 1, 0, 0, 4);
    add(0, 0, 1, 8'h00, 1, 1, 0, 0, 4);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst = vecs[i].r; en = vecs[i].e; fifo_empty = vecs[i].empty; fifo_rdata = vecs[i].data;
      #2;
      chk("vec_tx", int'(tx), int'(vecs[i].x_tx));
      chk("vec_busy", int'(busy), int'(vecs[i].x_busy));
      chk("vec_pop", int'(fifo_pop), int'(vecs[i].x_pop));
      chk("vec_done", int'(frame_done), int'(vecs[i].x_done));
      @(posedge clk); #1;
    end
    $display("table: %0d vectors applied", vecs.size());

    // Single 0xA5 frame after a reset with a non-empty FIFO.
    raw_reset();
    fifo_q.push_back(8'hA5);
    for (int i = 0; i < 3; i++) run_cycle(1, 1, 0);
    clear_stats();
    for (int i = 0; i < 45; i++) run_cycle(0, 1, 0);
    chk("a5_pops", pop_cnt, 1);
    chk("a5_busy_cycles", busy_cnt, 40);
    chk("a5_done_cycle", last_done - pop_at(0), 40);
    $display("frame 0xA5: pops=%0d busy=%0d done_at=%0d", pop_cnt, busy_cnt, last_done - pop_at(0));

    // Back-to-back 0x00 then 0xFF.
    raw_reset();
    fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF);
    clear_stats();
    for (int i = 0; i < 90; i++) run_cycle(0, 1, 0);
    chk("b2b_pops", pop_cnt, 2);
    chk("b2b_pop_gap", pop_at(1) - pop_at(0), 40);
    chk("b2b_busy_run", busy_run_max, 80);
    $display("frames 0x00,0xFF: pops=%0d gap=%0d busy_run=%0d", pop_cnt, pop_at(1) - pop_at(0), busy_run_max);

    // en dropped at cycle 10 of a 0x3C frame with more data waiting.
    raw_reset();
    fifo_q.push_back(8'h3C); fifo_q.push_back(8'h11);
    clear_stats();
    for (int i = 0; i < 60; i++) run_cycle(0, i < 10, 0);
    chk("en_drop_pops", pop_cnt, 1);
    chk("en_drop_done", last_done - pop_at(0), 40);
    chk("en_drop_busy", busy_cnt, 40);
    chk("en_drop_fifo_left", fifo_q.size(), 1);
    $display("frame 0x3C en drop: pops=%0d done_at=%0d", pop_cnt, last_done);

    // Reset in the middle of data bit 3; the aborted word stays consumed.
    raw_reset();
    fifo_q.push_back(8'h55); fifo_q.push_back(8'h66);
    clear_stats();
    for (int i = 0; i < 60; i++) begin
      run_cycle(i == 18, 1, 0);
      if (i == 18) begin
        chk("rst_mid_tx", int'(tx), 1);
        chk("rst_mid_busy", int'(busy), 0);
      end
    end
    chk("rst_mid_pops", pop_cnt, 2);
    chk("rst_mid_repop_cycle", pop_at(1), 19);
    $display("frame 0x55 reset mid-data: pops=%0d next_pop=%0d", pop_cnt, pop_at(1));

`ifdef UART_TX_DRAIN_PARITY_EN
    raw_reset();
    fifo_q.push_back(8'h07);
    clear_stats();
    for (int i = 0; i < 50; i++) run_cycle(0, 1, 0);
    chk("parity_done_cycle", last_done - pop_at(0), 44);
    chk("parity_busy", busy_cnt, 44);
    $display("frame 0x07 parity: done_at=%0d", last_done - pop_at(0));
`endif

    // Random traffic: sporadic pushes, en/empty jitter, rare resets.
    raw_reset();
    clear_stats();
    for (int i = 0; i < 3000; i++) begin
      if (($urandom_range(0, 19) == 0) && (fifo_q.size() < 4)) fifo_q.push_back(W'($urandom));
      run_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0);
    end
    $display("random: %0d cycles, %0d pops", cyc, pop_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per frame (legal 5..9).
REQ-002 Parameter: CLK_DIV, default 16, clock cycles per serial bit (legal >= 2).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: en  input  1  transmit enable; sampled only when deciding to start a frame.
REQ-006 Port: fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 Port: fifo_rdata  input  WIDTH  upstream FIFO head word, valid whenever fifo_empty=0.
REQ-008 Port: fifo_pop  output  1  one-cycle pop strobe to upstream FIFO.
REQ-009 Port: tx  output  1  serial line, idle high, registered.
REQ-010 Port: busy  output  1  high while a frame is in progress.
REQ-011 Port: frame_done  output  1  one-cycle pulse in the last cycle of a stop bit.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY (only with macro), STOP; busy = (state != IDLE).
REQ-013 Start condition: state IDLE, or last cycle of STOP, with en=1 and fifo_empty=0.
REQ-014 On start condition: fifo_pop=1 for that cycle only (combinational from state/timer/en/fifo_empty); fifo_rdata loaded into shift register at that edge; next state START.
REQ-015 fifo_pop never asserts while fifo_empty=1, and at most once per frame.
REQ-016 Bit timer loads CLK_DIV-1 on entering each bit and counts down to 0; each bit lasts exactly CLK_DIV cycles.
REQ-017 tx levels: START 0; DATA shift-register bits LSB first, WIDTH bits; PARITY even parity bit; STOP 1; IDLE 1.
REQ-018 tx changes only on bit boundaries; first START-bit cycle is the cycle after fifo_pop.
REQ-019 Frame length: (WIDTH+2)*CLK_DIV cycles without parity, (WIDTH+3)*CLK_DIV with parity.
REQ-020 Back-to-back: if start condition holds in the last STOP cycle, next START follows with zero idle cycles.
REQ-021 Otherwise, at end of STOP, state goes to IDLE with tx=1.
REQ-022 en deasserted mid-frame: current frame completes unaltered; no further pop until en=1.
REQ-023 fifo_empty/fifo_rdata changes mid-frame have no effect on the frame in flight.
REQ-024 frame_done pulses once per frame, coincident with the final STOP cycle (same cycle as any back-to-back pop).

Reset
REQ-025 rst=1 at a clock edge: state IDLE, timer 0, bit index 0, shift register 0, tx=1, busy=0, frame_done=0.
REQ-026 fifo_pop=0 in every cycle rst=1.
REQ-027 Reset mid-frame aborts the frame: tx=1 from the cycle after the edge; the aborted word is not re-popped.

Configuration
REQ-028 Macro UART_TX_DRAIN_PARITY_EN defined: PARITY state compiled in, one even-parity bit (XOR of the WIDTH data bits) between DATA and STOP.
REQ-029 Macro undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Verification (WIDTH=8, CLK_DIV=4)
REQ-030 rst=1 for 3 cycles, fifo_empty=0, en=1 -> tx=1, busy=0, fifo_pop=0, frame_done=0 throughout.
REQ-031 en=1, one word 0xA5 -> one fifo_pop pulse; tx: 0x4, then 1,0,1,0,0,1,0,1 each x4, then 1x4; frame_done in cycle 40; busy 40 cycles.
REQ-032 Words 0x00 then 0xFF queued -> second pop in frame-1's last STOP cycle; 80 contiguous busy cycles; tx never idles between frames.
REQ-033 en dropped in cycle 10 of a 0x3C frame, FIFO still non-empty -> frame completes at cycle 40; no further pop; tx=1, busy=0 thereafter.
REQ-034 rst pulsed during DATA bit 3 -> tx=1 and busy=0 the next cycle; no pop until rst=0 and the start condition holds again.
REQ-035 With UART_TX_DRAIN_PARITY_EN, word 0x07 -> parity bit 1 in cycles 37-40, stop bit in cycles 41-44, frame_done in cycle 44.
